// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NREAD = 2;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]   reg_idx_t;
    typedef logic [DEF_XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Issue/writeback/read bundle of regfile_sb; master drives requests, slave is the register file.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NREAD = DEF_NREAD
);
    localparam int AW = $clog2(NREGS);

    logic                  wen;
    logic [AW-1:0]         regW_sel;
    logic [XLEN-1:0]       regW_i;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_sel;
    logic [NREAD*AW-1:0]   reg_sel;
    logic [NREAD*XLEN-1:0] reg_o;
    logic [NREAD-1:0]      busy_o;
    logic [AW:0]           busy_cnt_o;

    modport master (
        output wen, regW_sel, regW_i, rsv_en, rsv_sel, reg_sel,
        input  reg_o, busy_o, busy_cnt_o
    );

    modport slave (
        input  wen, regW_sel, regW_i, rsv_en, rsv_sel, reg_sel,
        output reg_o, busy_o, busy_cnt_o
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: writeback releases, issue reserves (reserve wins), plus a
// registered popcount that always matches the stored vector.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wen,
    input  logic [AW-1:0]    i_wsel,
    input  logic             i_rsv_en,
    input  logic [AW-1:0]    i_rsv_sel,
    output logic [NREGS-1:0] o_busy,
    output logic [AW:0]      o_busy_cnt
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      r_cnt;
    logic [AW:0]      w_cnt_nxt;

    // NOTE: every comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wen && (i_wsel != '0)) begin
            w_busy_nxt[i_wsel] = 1'b0;
        end
        // Reservation is applied last: the issuing instruction is younger than the writer.
        if (i_rsv_en && (i_rsv_sel != '0)) begin
            w_busy_nxt[i_rsv_sel] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with busy scoreboard; x0 is hardwired zero.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NREAD = DEF_NREAD,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    logic [XLEN-1:0]       r_mem [NREGS];
    logic [NREGS-1:0]      w_busy;
    logic [NREAD*XLEN-1:0] w_reg_o;
    logic [NREAD-1:0]      w_busy_o;
    logic [AW-1:0]         w_idx;

    // NOTE: the array is reset entry by entry because a reset must clear every register,
    // which rules out block RAM; entry 0 is never written and so stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.wen && (bus.regW_sel != '0)) begin
            r_mem[bus.regW_sel] <= bus.regW_i;
        end
    end

    regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_wen      (bus.wen),
        .i_wsel     (bus.regW_sel),
        .i_rsv_en   (bus.rsv_en),
        .i_rsv_sel  (bus.rsv_sel),
        .o_busy     (w_busy),
        .o_busy_cnt (bus.busy_cnt_o)
    );

    always_comb begin
        w_reg_o  = '0;
        w_busy_o = '0;
        w_idx    = '0;
        for (int p = 0; p < NREAD; p++) begin
            w_idx                     = bus.reg_sel[p*AW +: AW];
            w_reg_o[p*XLEN +: XLEN]   = r_mem[w_idx];
            w_busy_o[p]               = w_busy[w_idx];
`ifdef REGFILE_BYPASS_EN
            if (bus.wen && (bus.regW_sel != '0) && (w_idx == bus.regW_sel)) begin
                w_reg_o[p*XLEN +: XLEN] = bus.regW_i;
                w_busy_o[p]             = 1'b0;
            end
`endif
            // Reads are forced low during reset so forwarding cannot leak through.
            if (rst) begin
                w_reg_o[p*XLEN +: XLEN] = '0;
                w_busy_o[p]             = 1'b0;
            end
        end
    end

    assign bus.reg_o  = w_reg_o;
    assign bus.busy_o = w_busy_o;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: array-based reference model, per-cycle compare,
// directed scoreboard/bypass/reset cases and a randomized phase.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    xlen_t m_mem  [NREGS];
    logic  m_busy [NREGS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural registers and busy bits as plain arrays.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_mem[i]  <= '0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (bus.wen && bus.regW_sel != 0) begin
                m_mem[bus.regW_sel]  <= bus.regW_i;
                m_busy[bus.regW_sel] <= 1'b0;
            end
            if (bus.rsv_en && bus.rsv_sel != 0) begin
                m_busy[bus.rsv_sel] <= 1'b1;
            end
        end
    end

    // Per-cycle compare, mid-way between rising edges.
    always @(negedge clk) begin : cmp
        int    cnt;
        int    sel;
        xlen_t exp_d;
        logic  exp_b;
        cnt = 0;
        for (int i = 1; i < NREGS; i++) cnt += int'(m_busy[i]);
        check("busy_cnt", 32'(bus.busy_cnt_o), rst ? 32'd0 : 32'(cnt));
        for (int p = 0; p < NREAD; p++) begin
            sel   = int'(bus.reg_sel[p*AW +: AW]);
            exp_d = m_mem[sel];
            exp_b = m_busy[sel];
`ifdef REGFILE_BYPASS_EN
            if (bus.wen && bus.regW_sel != 0 && sel == int'(bus.regW_sel)) begin
                exp_d = bus.regW_i;
                exp_b = 1'b0;
            end
`endif
            if (rst) begin
                exp_d = '0;
                exp_b = 1'b0;
            end
            check($sformatf("rd%0d_data", p), bus.reg_o[p*XLEN +: XLEN], exp_d);
            check($sformatf("rd%0d_busy", p), 32'(bus.busy_o[p]), 32'(exp_b));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.wen      = 1'b0;
        bus.regW_sel = '0;
        bus.regW_i   = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_sel  = '0;
        bus.reg_sel  = '0;

        // Reset then idle: every index reads zero on both ports.
        for (int i = 0; i < NREGS; i++) begin
            bus.reg_sel = {5'(i), 5'(NREGS - 1 - i)};
            #3;
            check("rst_rd0", bus.reg_o[31:0], 32'h0);
            check("rst_rd1", bus.reg_o[63:32], 32'h0);
            check("rst_busy", 32'(bus.busy_o), 32'h0);
        end
        check("rst_cnt", 32'(bus.busy_cnt_o), 32'h0);
        tick();
        rst = 1'b0;

        // Fill every index with random data, then cross-sweep both ports.
        for (int i = 0; i < NREGS; i++) begin
            bus.wen      = 1'b1;
            bus.regW_sel = 5'(i);
            bus.regW_i   = $urandom;
            tick();
        end
        bus.wen = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            bus.reg_sel = {5'(i), 5'(NREGS - 1 - i)};
            tick();
        end
        bus.reg_sel = {5'd0, 5'd0};
        #1;
        check("x0_rd0", bus.reg_o[31:0], 32'h0);
        check("x0_rd1", bus.reg_o[63:32], 32'h0);

        // Reserve x5, then release it by writeback.
        bus.reg_sel = {5'd0, 5'd5};
        bus.rsv_en  = 1'b1;
        bus.rsv_sel = 5'd5;
        tick();
        bus.rsv_en = 1'b0;
        check("rsv5_busy", 32'(bus.busy_o[0]), 32'h1);
        check("rsv5_cnt", 32'(bus.busy_cnt_o), 32'h1);
        bus.wen      = 1'b1;
        bus.regW_sel = 5'd5;
        bus.regW_i   = 32'hDEADBEEF;
        tick();
        bus.wen = 1'b0;
        check("wr5_data", bus.reg_o[31:0], 32'hDEADBEEF);
        check("wr5_busy", 32'(bus.busy_o[0]), 32'h0);
        check("wr5_cnt", 32'(bus.busy_cnt_o), 32'h0);

        // Simultaneous write and reserve of x7: data lands, reserve wins.
        bus.reg_sel  = {5'd0, 5'd7};
        bus.wen      = 1'b1;
        bus.regW_sel = 5'd7;
        bus.regW_i   = 32'h1234;
        bus.rsv_en   = 1'b1;
        bus.rsv_sel  = 5'd7;
        tick();
        bus.wen    = 1'b0;
        bus.rsv_en = 1'b0;
        check("wr7_data", bus.reg_o[31:0], 32'h1234);
        check("wr7_busy", 32'(bus.busy_o[0]), 32'h1);
        check("wr7_cnt", 32'(bus.busy_cnt_o), 32'h1);

        // Same-cycle read of the index being written.
        bus.wen      = 1'b1;
        bus.regW_sel = 5'd3;
        bus.regW_i   = 32'h11111111;
        tick();
        bus.regW_i  = 32'hA5A5A5A5;
        bus.reg_sel = {5'd0, 5'd3};
        #2;
`ifdef REGFILE_BYPASS_EN
        check("byp3_pre", bus.reg_o[31:0], 32'hA5A5A5A5);
`else
        check("byp3_pre", bus.reg_o[31:0], 32'h11111111);
`endif
        tick();
        bus.wen = 1'b0;
        check("byp3_post", bus.reg_o[31:0], 32'hA5A5A5A5);

        // Mid-operation reset.
        bus.wen      = 1'b1;
        bus.regW_sel = 5'd9;
        bus.regW_i   = 32'hFFFFFFFF;
        for (int i = 1; i <= 4; i++) begin
            bus.rsv_en  = 1'b1;
            bus.rsv_sel = 5'(i);
            tick();
            bus.wen = 1'b0;
        end
        bus.rsv_en  = 1'b0;
        bus.reg_sel = {5'd1, 5'd9};
        #1;
        check("pre_rst_x9", bus.reg_o[31:0], 32'hFFFFFFFF);
        check("pre_rst_b1", 32'(bus.busy_o[1]), 32'h1);
        check("pre_rst_cnt", 32'(bus.busy_cnt_o), 32'd5);
        #1;
        bus.wen      = 1'b1;
        bus.regW_sel = 5'd9;
        bus.regW_i   = 32'h55;
        rst          = 1'b1;
        #1;
        check("in_rst_rd0", bus.reg_o[31:0], 32'h0);
        check("in_rst_rd1", bus.reg_o[63:32], 32'h0);
        check("in_rst_busy", 32'(bus.busy_o), 32'h0);
        check("in_rst_cnt", 32'(bus.busy_cnt_o), 32'h0);
        tick();
        bus.wen = 1'b0;
        rst     = 1'b0;
        #1;
        check("post_rst_x9", bus.reg_o[31:0], 32'h0);
        check("post_rst_cnt", 32'(bus.busy_cnt_o), 32'h0);

        // Randomized traffic, biased so reads often hit the written index.
        for (int n = 0; n < 400; n++) begin
            bus.wen      = ($urandom_range(0, 1) == 1);
            bus.regW_sel = 5'($urandom_range(0, NREGS - 1));
            bus.regW_i   = $urandom;
            bus.rsv_en   = ($urandom_range(0, 2) == 0);
            bus.rsv_sel  = ($urandom_range(0, 3) == 0) ? bus.regW_sel
                                                       : 5'($urandom_range(0, NREGS - 1));
            bus.reg_sel  = {5'($urandom_range(0, NREGS - 1)),
                            ($urandom_range(0, 2) == 0) ? bus.regW_sel
                                                        : 5'($urandom_range(0, NREGS - 1))};
            tick();
        end
        bus.wen    = 1'b0;
        bus.rsv_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with a per-register busy scoreboard, the successor to the two-read/one-write `regfile`. It sits between decode/issue and writeback of the pipelined RISC-V core. Issue reserves destination registers; writeback stores results and releases the reservation. Every read port returns both data and a busy flag so hazard logic can stall without a separate scoreboard.

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of architectural registers, power of two ≥ 2; register 0 is hardwired zero.
- `NREAD`, 2, number of read ports, 1..4.
- `AW`, `$clog2(NREGS)`, register-index width, derived (not overridden).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wen`  in  1  writeback enable.
- `regW_sel`  in  AW  writeback register index.
- `regW_i`  in  XLEN  writeback data.
- `rsv_en`  in  1  issue reservation enable.
- `rsv_sel`  in  AW  register to mark busy.
- `reg_sel`  in  NREAD×AW  read indices, packed, port p at `[p*AW +: AW]`.
- `reg_o`  out  NREAD×XLEN  read data, packed likewise.
- `busy_o`  out  NREAD  busy flag per read port.
- `busy_cnt_o`  out  AW+1  number of registers currently busy.

## Operation
- Reads are combinational: `reg_o[p]` = `mem[reg_sel[p]]`, and `busy_o[p]` = `busy[reg_sel[p]]`. Ports are fully independent, and any ports may select the same index.
- Index 0 always reads 0 with busy 0. Writes and reservations to index 0 are ignored.
- Write: on a rising edge with `wen=1` and `regW_sel≠0`, `mem[regW_sel]` ← `regW_i` and `busy[regW_sel]` ← 0.
- Reserve: on a rising edge with `rsv_en=1` and `rsv_sel≠0`, `busy[rsv_sel]` ← 1.
- Write and reserve of the same nonzero index in one cycle:
  - The data is written.
  - Busy ends at 1, because the new producer is the younger instruction and reserve wins.
- Reserving an already-busy register leaves it busy. There is no counting and no error.
- Writing a non-busy register is legal, and busy stays 0.
- `busy_cnt_o` is the registered population count of `busy[NREGS-1:1]`. It is updated on the same edge as `busy` and equals popcount of the new vector. The range is 0..NREGS-1.
- Reset (asserted at any time, including mid-write):
  - all `mem` entries ← 0;
  - all `busy` ← 0;
  - `busy_cnt_o` ← 0;
  - all `reg_o` and `busy_o` read 0 while `rst` is high.
  - Inputs are ignored while `rst` is high.

## Timing
- Read latency is 0 cycles (combinational from `reg_sel` and state).
- Write latency: data is visible on `reg_o` after the capturing edge. Same-cycle behaviour depends on `REGFILE_BYPASS_EN`.
- Reserve latency: `busy_o` is 1 from the edge after `rsv_en`.
- `busy_cnt_o` is registered and consistent with `busy` in the same cycle.
- `rst` deassertion is synchronised externally by the top level. The block needs no deassertion sequencing.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: write-to-read forwarding.
  - When `wen=1`, `regW_sel≠0` and `reg_sel[p]==regW_sel`, `reg_o[p]` = `regW_i` and `busy_o[p]` = 0 in the same cycle.
  - This holds even if `rsv_en` targets the same index, because the reservation takes effect next cycle.
- Undefined: `reg_o` and `busy_o` reflect stored state only, and the new value appears after the edge.
- Storage and scoreboard behaviour are identical in both builds.

## Structure
- `regfile_pkg`: default `XLEN`, `NREGS`, `NREAD` localparams; `reg_idx_t` typedef (`logic [AW-1:0]`); `xlen_t` typedef.
- Sub-module `regfile_scoreboard`: owns the busy vector, reserve/release priority and `busy_cnt_o`.
- `regfile_sb` holds the data array, read muxes and optional bypass, and instantiates `regfile_scoreboard`.

## Test plan
- Reset then idle: with `rst` pulsed, all ports at every index 0..31 read data 0, busy 0, `busy_cnt_o`=0.
- Fill and read back:
  - Write random values to indices 0..31 with `wen=1`, one per cycle.
  - All ports read back the expected value; index 0 reads 0.
  - Port 0 sweeps 31→0 while port 1 sweeps 0→31, and both match.
- Scoreboard:
  - Reserve x5 → next cycle `busy_o`=1 on a port selecting 5, `busy_cnt_o`=1.
  - Write x5=`32'hDEADBEEF` → next cycle busy 0, data `DEADBEEF`, count 0.
- Simultaneous write and reserve of x7 (`32'h1234`) → next cycle data `1234`, busy 1, count 1.
- Same-cycle read of the written index, x3=`32'hA5A5A5A5`, `reg_sel`=3:
  - With `REGFILE_BYPASS_EN`: `reg_o`=`A5A5A5A5` before the edge.
  - Without it: the old value before the edge, the new value after.
- Mid-operation reset:
  - Reserve x1..x4 and write x9=`32'hFFFFFFFF`.
  - Assert `rst` between edges → outputs immediately 0 and `busy_cnt_o`=0; after deassertion x9 reads 0.
